// File: rtl/vga_pkg.sv
// Purpose : shared timing constants, helpers and types for the VGA raster
//           timing generator (default mode 640x480@60).
// Contents: default horizontal/vertical timing, H_TOTAL/V_TOTAL helpers,
//           sync polarity encoding and the sync/blank bundle that travels
//           through the renderer-matching delay line.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Polarity encoding: the value is the level the pin takes while asserted.
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Bundle of pin-side timing signals, delayed together.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_bits_t;

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Pin level for a sync signal given its polarity and whether it is asserted.
    function automatic logic sync_level(input logic pol, input logic asserted);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Purpose : parameterised shift register with a synchronous reset value,
//           used to line sync/blank up with the renderer's RGB latency.
// Ports   : clk   - clock
//           reset - synchronous active-high reset, loads RESET_VAL in every stage
//           d     - input word (WIDTH bits)
//           q     - output word, d delayed by DEPTH clocks (DEPTH >= 1)
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Next value of each stage: stage 0 takes the input, others shift along.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset flushes the whole line to the idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// Purpose : raster timing generator for the VGA pixel stage (vga_clk domain).
//           Free-running h/v counters feed a registered stage 0 (coordinates,
//           active, line/frame strobes, sync/blank). Sync/blank then pass
//           through a PIPE_DELAY-deep delay line to match renderer latency.
// Ports   : vga_clk     in   pixel clock
//           reset       in   synchronous active-high reset
//           x, y        out  10-bit pixel column/row (counter values, 1-clk latency)
//           active      out  (x,y) inside the visible area
//           line_start  out  1-clock pulse at h==0
//           frame_start out  1-clock pulse at h==0 && v==0
//           vga_hs      out  horizontal sync, 1+PIPE_DELAY clocks after counter
//           vga_vs      out  vertical sync, 1+PIPE_DELAY clocks after counter
//           vga_blank_n out  0 outside the visible area, same latency as syncs
//           vga_sync_n  out  tied 0 (no sync-on-green)
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = SYNC_ACTIVE_LOW,
    parameter logic VS_POL     = SYNC_ACTIVE_LOW,
    parameter int   PIPE_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_sync_n
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Elaboration-time sanity checks on the timing parameters.
    if (H_TOTAL > (1 << CNT_W)) begin : g_chk_h
        $error("vga_timing: horizontal total does not fit the 10-bit counter");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_chk_v
        $error("vga_timing: vertical total does not fit the 10-bit counter");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_chk_pd
        $error("vga_timing: PIPE_DELAY must be in 0..15");
    end

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Comparisons run one bit wider so an end bound of exactly 1024 still fits.
    localparam logic [CNT_W:0] H_ACT_L  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_L  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bits_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};

    logic [CNT_W-1:0] h_d, h_q;
    logic [CNT_W-1:0] v_d, v_q;
    logic [CNT_W:0]   h_ext_s;
    logic [CNT_W:0]   v_ext_s;

    logic [CNT_W-1:0] x_d, x_q;
    logic [CNT_W-1:0] y_d, y_q;
    logic             active_d, active_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;
    sync_bits_t       sync0_d, sync0_q;
    sync_bits_t       sync_out_s;

    assign h_ext_s = {1'b0, h_q};
    assign v_ext_s = {1'b0, v_q};

    // Counter next-state: h wraps at H_LAST, v advances only on h wrap.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = {CNT_W{1'b0}};
            if (v_q == V_LAST) begin
                v_d = {CNT_W{1'b0}};
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    // Stage-0 decode of the current counter state. vs follows v, which only
    // moves on h wrap, so vs edges land on line boundaries.
    always_comb begin
        x_d           = h_q;
        y_d           = v_q;
        active_d      = (h_ext_s < H_ACT_L) && (v_ext_s < V_ACT_L);
        line_start_d  = (h_q == 10'd0);
        frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
        sync0_d.hs    = sync_level(HS_POL, (h_ext_s >= HS_START) && (h_ext_s < HS_END));
        sync0_d.vs    = sync_level(VS_POL, (v_ext_s >= VS_START) && (v_ext_s < VS_END));
        sync0_d.blank_n = active_d;
    end

    // Counters and stage-0 registers; reset drives every output inactive.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync0_q       <= SYNC_IDLE;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sync0_q       <= sync0_d;
        end
    end

    // With no renderer latency the pins are taken straight from stage 0.
    if (PIPE_DELAY == 0) begin : g_no_delay
        assign sync_out_s = sync0_q;
    end else begin : g_delay
        vga_delay_line #(
            .WIDTH     (3),
            .DEPTH     (PIPE_DELAY),
            .RESET_VAL (SYNC_IDLE)
        ) u_delay (
            .clk   (vga_clk),
            .reset (reset),
            .d     (sync0_q),
            .q     (sync_out_s)
        );
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = sync_out_s.hs;
    assign vga_vs      = sync_out_s.vs;
    assign vga_blank_n = sync_out_s.blank_n;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing using a reduced raster so whole frames fit a
// short run: H 16/2/4/2 (total 24), V 8/1/2/1 (total 12), frame = 288 clocks.
// Hand-derived positions in this mode:
//   hs asserted for h = 18..21, vs asserted for v = 9..10 (both active-low),
//   visible area h < 16, v < 8.
// Two instances share clock/reset: dut_a with PIPE_DELAY=2, dut_b with 0.
module tb_vga_timing;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic act_a, ls_a, fs_a, hs_a, vs_a, bl_a, sn_a;
    logic act_b, ls_b, fs_b, hs_b, vs_b, bl_b, sn_b;

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(2)
    ) dut_a (
        .vga_clk(clk), .reset(reset), .x(x_a), .y(y_a), .active(act_a),
        .line_start(ls_a), .frame_start(fs_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vga_blank_n(bl_a), .vga_sync_n(sn_a)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0)
    ) dut_b (
        .vga_clk(clk), .reset(reset), .x(x_b), .y(y_b), .active(act_b),
        .line_start(ls_b), .frame_start(fs_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vga_blank_n(bl_b), .vga_sync_n(sn_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected {hs, vs, blank_n} for counter index m since reset release;
    // negative m means the value is still the reset fill of the delay line.
    function automatic logic [2:0] exp_pins(input int m);
        int h;
        int v;
        if (m < 0) return 3'b110;
        h = m % 24;
        v = (m / 24) % 12;
        return {!(h >= 18 && h <= 21), !(v >= 9 && v <= 10), (h < 16) && (v < 8)};
    endfunction

    // Compare every output against the index-based model for post-release edge n.
    task automatic check_cycle(input int n);
        int h;
        int v;
        logic [2:0] pa;
        logic [2:0] pb;
        h  = n % 24;
        v  = (n / 24) % 12;
        pa = exp_pins(n - 2);
        pb = exp_pins(n);
        check_eq("x",           {22'd0, x_a}, h);
        check_eq("y",           {22'd0, y_a}, v);
        check_eq("active",      {31'd0, act_a}, {31'd0, (h < 16) && (v < 8)});
        check_eq("line_start",  {31'd0, ls_a}, {31'd0, h == 0});
        check_eq("frame_start", {31'd0, fs_a}, {31'd0, (h == 0) && (v == 0)});
        check_eq("hs_pd2",      {31'd0, hs_a}, {31'd0, pa[2]});
        check_eq("vs_pd2",      {31'd0, vs_a}, {31'd0, pa[1]});
        check_eq("blank_n_pd2", {31'd0, bl_a}, {31'd0, pa[0]});
        check_eq("x_pd0",       {22'd0, x_b}, h);
        check_eq("active_pd0",  {31'd0, act_b}, {31'd0, (h < 16) && (v < 8)});
        check_eq("hs_pd0",      {31'd0, hs_b}, {31'd0, pb[2]});
        check_eq("vs_pd0",      {31'd0, vs_b}, {31'd0, pb[1]});
        check_eq("blank_n_pd0", {31'd0, bl_b}, {31'd0, pb[0]});
    endtask

    int fs_cnt, ls_cnt, act_cnt;
    int last_fs, last_ls;
    int hs_run, hs_runs, vs_run, vs_runs;
    int first_hs_a, first_hs_b, first_vs_a, first_act, first_bl_a, first_bl_b;

    initial begin
        fs_cnt = 0; ls_cnt = 0; act_cnt = 0;
        last_fs = -1; last_ls = -1;
        hs_run = 0; hs_runs = 0; vs_run = 0; vs_runs = 0;
        first_hs_a = -1; first_hs_b = -1; first_vs_a = -1;
        first_act = -1; first_bl_a = -1; first_bl_b = -1;

        // Reset held for 5 clocks: every output inactive.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("rst_hs",     {31'd0, hs_a},  32'd1);
            check_eq("rst_vs",     {31'd0, vs_a},  32'd1);
            check_eq("rst_blank",  {31'd0, bl_a},  32'd0);
            check_eq("rst_active", {31'd0, act_a}, 32'd0);
            check_eq("rst_fs",     {31'd0, fs_a},  32'd0);
            check_eq("rst_hs_pd0", {31'd0, hs_b},  32'd1);
        end
        check_eq("sync_n", {31'd0, sn_a}, 32'd0);
        reset = 1'b0;

        // Two frames plus one line of free run with period/width measurement.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            check_cycle(n);
            if (n < 576) begin
                if (fs_a) fs_cnt++;
                if (ls_a) ls_cnt++;
                if (act_a) act_cnt++;
            end
            if (fs_a) begin
                if (last_fs >= 0) check_eq("frame_period", n - last_fs, 32'd288);
                last_fs = n;
            end
            if (ls_a) begin
                if (last_ls >= 0) check_eq("line_period", n - last_ls, 32'd24);
                last_ls = n;
            end
            if (!hs_a) begin
                hs_run++;
                if (first_hs_a < 0) first_hs_a = n;
            end else if (hs_run != 0) begin
                check_eq("hs_width", hs_run, 32'd4);
                hs_runs++;
                hs_run = 0;
            end
            if (!vs_a) begin
                vs_run++;
                if (first_vs_a < 0) first_vs_a = n;
            end else if (vs_run != 0) begin
                check_eq("vs_width", vs_run, 32'd48);
                vs_runs++;
                vs_run = 0;
            end
            if (!hs_b && first_hs_b < 0) first_hs_b = n;
            if (act_a && first_act < 0) first_act = n;
            if (bl_a && first_bl_a < 0) first_bl_a = n;
            if (bl_b && first_bl_b < 0) first_bl_b = n;
        end
        check_eq("frame_count",   fs_cnt,  32'd2);
        check_eq("line_count",    ls_cnt,  32'd24);
        check_eq("active_clks",   act_cnt, 32'd256);
        check_eq("hs_runs",       hs_runs, 32'd24);
        check_eq("vs_runs",       vs_runs, 32'd2);
        check_eq("hs_start_pd2",  first_hs_a, 32'd20);
        check_eq("hs_start_pd0",  first_hs_b, 32'd18);
        check_eq("vs_start_pd2",  first_vs_a, 32'd218);
        check_eq("blank_lag_pd2", first_bl_a - first_act, 32'd2);
        check_eq("blank_lag_pd0", first_bl_b - first_act, 32'd0);

        // Run into frame 3 up to counter (h=20, v=9): inside both syncs.
        for (int n = 600; n <= 812; n++) begin
            @(posedge clk); #1;
            check_cycle(n);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_hs",     {31'd0, hs_a},  32'd1);
        check_eq("mid_rst_vs",     {31'd0, vs_a},  32'd1);
        check_eq("mid_rst_blank",  {31'd0, bl_a},  32'd0);
        check_eq("mid_rst_hs_pd0", {31'd0, hs_b},  32'd1);
        check_eq("mid_rst_vs_pd0", {31'd0, vs_b},  32'd1);
        check_eq("mid_rst_active", {31'd0, act_a}, 32'd0);
        check_eq("mid_rst_ls",     {31'd0, ls_a},  32'd0);
        check_eq("mid_rst_x",      {22'd0, x_a},   32'd0);
        reset = 1'b0;

        // Restart from (0,0) with a flushed delay line and no stray pulses.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            check_cycle(n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
